// File: rtl/pos_sweep_capture.sv
// Steps a 4-input PoS block through all 16 vectors, samples r after SETTLE cycles per vector,
// and grades the captured truth table against EXPECTED (error count, first failing index, pass).
module pos_sweep_capture #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h1894
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        r_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] tt_q, tt_d;
  logic        pass_q, pass_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          vec_d   = 4'd0;
          busy_d  = 1'b1;
          tt_d    = 16'h0000;
          pass_d  = 1'b0;
          err_d   = 5'd0;
          ffi_d   = 4'd0;
          ffv_d   = 1'b0;
        end
      end
      S_WAIT: begin
        // abort wins over a sample landing on the same edge
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          vec_d   = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
          tt_d[idx_q] = r_in;
          if (r_in != EXPECTED[idx_q]) begin
            err_d = err_q + 5'd1;
            if (!ffv_q) begin
              ffi_d = idx_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = idx_q + 4'd1;
            cnt_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 5'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= 16'h0000;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      ffi_q   <= 4'd0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
    end
  end

  assign {a, b, c, d}     = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign tt               = tt_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_pos_sweep_capture.sv
// Bench for pos_sweep_capture: SETTLE=1 and SETTLE=3 instances, scoreboard of expected sweep results.
module tb_pos_sweep_capture;

  typedef struct packed {
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ffi;
    logic        ffv;
  } obs_t;

  typedef struct packed {
    logic [15:0] tt;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ffi;
    logic        ffv;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic r1, r3;
  int   mode1 = 0, mode3 = 0;
  logic [15:0] gold = 16'h1894;

  logic a1, b1, c1, d1, busy1, done1, pass1, ffv1;
  logic a3, b3, c3, d3, busy3, done3, pass3, ffv3;
  logic [15:0] tt1, tt3;
  logic [4:0]  err1, err3;
  logic [3:0]  ffi1, ffi3;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pos_sweep_capture #(.SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .r_in(r1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .tt(tt1),
    .pass(pass1), .err_count(err1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  pos_sweep_capture #(.SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .r_in(r3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .tt(tt3),
    .pass(pass3), .err_count(err3), .first_fail_idx(ffi3), .first_fail_valid(ffv3)
  );

  // PoS block stand-in: correct function, stuck-at-0 or stuck-at-1
  always_comb begin
    r1 = (mode1 == 0) ? gold[{a1, b1, c1, d1}] : (mode1 == 2);
    r3 = (mode3 == 0) ? gold[{a3, b3, c3, d3}] : (mode3 == 2);
  end

  function automatic obs_t cur(input int sel);
    obs_t o;
    if (sel == 3) o = '{{a3, b3, c3, d3}, busy3, done3, tt3, pass3, err3, ffi3, ffv3};
    else          o = '{{a1, b1, c1, d1}, busy1, done1, tt1, pass1, err1, ffi1, ffv1};
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int mode, input int settle);
    exp_t e;
    logic r;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      r = (mode == 0) ? gold[i] : (mode == 2);
      e.tt[i] = r;
      if (r != gold[i]) begin
        e.err = e.err + 5'd1;
        if (!e.ffv) begin
          e.ffi = 4'(i);
          e.ffv = 1'b1;
        end
      end
    end
    e.pass = (e.err == 0);
    e.lat  = 8'(16 * settle + 1);
    return e;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v;
    else          start1 = v;
  endtask

  // Full sweep: push expectation at the start edge, pop and compare when done shows up
  task automatic sweep(input int sel, input int mode, input int settle, input string tag);
    exp_t e;
    obs_t o;
    int   lat;
    if (sel == 3) mode3 = mode;
    else          mode1 = mode;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    sb_q.push_back(model(mode, settle));
    o = cur(sel);
    check({tag, "_busy_start"}, 32'(o.busy), 32'd1);
    lat = 0;
    o.done = 1'b0;
    while (!o.done && lat < 300) begin
      tick();
      lat++;
      o = cur(sel);
      if (settle == 1 && lat <= 15)
        check({tag, "_vec"}, 32'(o.vec), 32'(lat));
    end
    e = sb_q.pop_front();
    if (!o.done) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_tt"}, 32'(o.tt), 32'(e.tt));
      check({tag, "_pass"}, 32'(o.pass), 32'(e.pass));
      check({tag, "_err"}, 32'(o.err), 32'(e.err));
      check({tag, "_ffv"}, 32'(o.ffv), 32'(e.ffv));
      if (e.ffv) check({tag, "_ffi"}, 32'(o.ffi), 32'(e.ffi));
      check({tag, "_busy_done"}, 32'(o.busy), 32'd0);
      check({tag, "_vec_last"}, 32'(o.vec), 32'hF);
      tick();
      o = cur(sel);
      check({tag, "_done_pulse"}, 32'(o.done), 32'd0);
      check({tag, "_tt_hold"}, 32'(o.tt), 32'(e.tt));
      check({tag, "_pass_hold"}, 32'(o.pass), 32'(e.pass));
    end
  endtask

  task automatic check_reset_state(input int sel, input string tag);
    obs_t o;
    o = cur(sel);
    check({tag, "_all"}, 32'(o), 32'd0);
  endtask

  initial begin
    obs_t o;
    int   seen_done;
    tick();
    tick();
    check_reset_state(1, "rst_s1");
    check_reset_state(3, "rst_s3");
    reset = 1'b0;
    tick();

    sweep(1, 0, 1, "s1_good");
    sweep(3, 0, 3, "s3_good");
    sweep(1, 1, 1, "s1_zero");
    sweep(1, 2, 1, "s1_one");
    sweep(3, 1, 3, "s3_zero");

    // Abort at idx=6 with start held high the whole time
    mode1 = 0;
    start1 = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    o = cur(1);
    check("abort_pre_vec", 32'(o.vec), 32'd6);
    abort1 = 1'b1;
    start1 = 1'b0;
    tick();
    abort1 = 1'b0;
    o = cur(1);
    check("abort_busy", 32'(o.busy), 32'd0);
    check("abort_vec", 32'(o.vec), 32'd0);
    check("abort_tt", 32'(o.tt), 32'h0014);
    check("abort_pass", 32'(o.pass), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done1) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    sweep(1, 0, 1, "abort_restart");

    // Reset mid-sweep at idx=9
    mode1 = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    o = cur(1);
    check("rst_pre_vec", 32'(o.vec), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state(1, "rst_mid");
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done1) seen_done = 1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    sweep(1, 0, 1, "rst_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
